// File: rtl/murmur_pkg.sv
// Shared MurMur finalizer constants and whole-word reference functions for the
// forward hash and its inverse, usable at either 32- or 64-bit key width.
package murmur_pkg;

    localparam int LATENCY = 5;

    localparam logic [31:0] MURMUR32_C1     = 32'h85ebca6b;
    localparam logic [31:0] MURMUR32_C2     = 32'hc2b2ae35;
    localparam logic [31:0] MURMUR32_C1_INV = 32'ha5cb9243;
    localparam logic [31:0] MURMUR32_C2_INV = 32'h7ed1b41d;

    localparam logic [63:0] MURMUR64_C1     = 64'hff51afd7ed558ccd;
    localparam logic [63:0] MURMUR64_C2     = 64'hc4ceb9fe1a85ec53;
    localparam logic [63:0] MURMUR64_C1_INV = 64'h4f74430c22a54005;
    localparam logic [63:0] MURMUR64_C2_INV = 64'h9cb4b2f8129337db;

    localparam int unsigned MURMUR32_SH_A = 32'd16;
    localparam int unsigned MURMUR32_SH_B = 32'd13;
    localparam int unsigned MURMUR64_SH   = 32'd33;

    function automatic logic [63:0] fmix_fwd(input logic [63:0] key, input int unsigned width);
        logic [31:0] h32;
        logic [63:0] h64;
        logic [63:0] result;
        h32 = key[31:0];
        h64 = key;
        if (width == 32'd32) begin
            h32 = h32 ^ (h32 >> MURMUR32_SH_A);
            h32 = h32 * MURMUR32_C1;
            h32 = h32 ^ (h32 >> MURMUR32_SH_B);
            h32 = h32 * MURMUR32_C2;
            h32 = h32 ^ (h32 >> MURMUR32_SH_A);
            result = {32'd0, h32};
        end else begin
            h64 = h64 ^ (h64 >> MURMUR64_SH);
            h64 = h64 * MURMUR64_C1;
            h64 = h64 ^ (h64 >> MURMUR64_SH);
            h64 = h64 * MURMUR64_C2;
            h64 = h64 ^ (h64 >> MURMUR64_SH);
            result = h64;
        end
        return result;
    endfunction

    function automatic logic [63:0] fmix_inv(input logic [63:0] hash, input int unsigned width);
        logic [31:0] x32;
        logic [63:0] x64;
        logic [63:0] result;
        x32 = hash[31:0];
        x64 = hash;
        if (width == 32'd32) begin
            x32 = x32 ^ (x32 >> MURMUR32_SH_A);
            x32 = x32 * MURMUR32_C2_INV;
            x32 = x32 ^ (x32 >> MURMUR32_SH_B) ^ (x32 >> (32'd2 * MURMUR32_SH_B));
            x32 = x32 * MURMUR32_C1_INV;
            x32 = x32 ^ (x32 >> MURMUR32_SH_A);
            result = {32'd0, x32};
        end else begin
            x64 = x64 ^ (x64 >> MURMUR64_SH);
            x64 = x64 * MURMUR64_C2_INV;
            x64 = x64 ^ (x64 >> MURMUR64_SH);
            x64 = x64 * MURMUR64_C1_INV;
            x64 = x64 ^ (x64 >> MURMUR64_SH);
            result = x64;
        end
        return result;
    endfunction

endpackage

// File: rtl/murmur_unhasher_if.sv
// Valid/ready stream bundle between a hash producer and the unhasher.
// Names are from the unhasher's point of view (i_* into it, o_* out of it).
interface murmur_unhasher_if #(
    parameter int unsigned KEY_WIDTH = 32
);
    logic [KEY_WIDTH-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic [KEY_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid
    );

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid
    );
endinterface

// File: rtl/murmur_pipe_stage.sv
// One pipeline slot: a key word plus valid bit that reloads from upstream whenever
// it is empty or its current contents are moving downstream this cycle.
module murmur_pipe_stage
    import murmur_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    input  logic [KEY_WIDTH-1:0] up_data,
    input  logic                 down_adv,
    output logic                 valid,
    output logic [KEY_WIDTH-1:0] data
);
    logic                 valid_r;
    logic [KEY_WIDTH-1:0] data_r;
    logic                 adv_s;

    assign adv_s = ~valid_r | down_adv;

    // Slot register: reset empties it, an advance loads whatever upstream offers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {KEY_WIDTH{1'b0}};
        end else if (adv_s) begin
            valid_r <= up_valid;
            data_r  <= up_data;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
endmodule

// File: rtl/murmur_unhasher.sv
// Inverse MurMur finalizer: five registered stages undo fmix32/fmix64 one step each,
// behind a valid/ready pipeline that collapses bubbles stage by stage.
module murmur_unhasher
    import murmur_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    murmur_unhasher_if.slave bus
);
    localparam int NUM_STAGES = LATENCY;

    localparam int unsigned SH_OUTER = (KEY_WIDTH == 32'd32) ? MURMUR32_SH_A : MURMUR64_SH;
    localparam int unsigned SH_MID   = (KEY_WIDTH == 32'd32) ? MURMUR32_SH_B : MURMUR64_SH;
    localparam int unsigned SH_MID2  = (KEY_WIDTH == 32'd32) ? (32'd2 * MURMUR32_SH_B) : MURMUR64_SH;
    // The 32-bit middle step needs a second xor-shift tap; the 64-bit one does not.
    localparam logic [KEY_WIDTH-1:0] MID2_MASK = (KEY_WIDTH == 32'd32) ? {KEY_WIDTH{1'b1}}
                                                                       : {KEY_WIDTH{1'b0}};
    localparam logic [KEY_WIDTH-1:0] C1_INV_K = (KEY_WIDTH == 32'd32) ? KEY_WIDTH'(MURMUR32_C1_INV)
                                                                      : KEY_WIDTH'(MURMUR64_C1_INV);
    localparam logic [KEY_WIDTH-1:0] C2_INV_K = (KEY_WIDTH == 32'd32) ? KEY_WIDTH'(MURMUR32_C2_INV)
                                                                      : KEY_WIDTH'(MURMUR64_C2_INV);

    localparam logic [31:0] PROD32_C1 = MURMUR32_C1 * MURMUR32_C1_INV;
    localparam logic [31:0] PROD32_C2 = MURMUR32_C2 * MURMUR32_C2_INV;
    localparam logic [63:0] PROD64_C1 = MURMUR64_C1 * MURMUR64_C1_INV;
    localparam logic [63:0] PROD64_C2 = MURMUR64_C2 * MURMUR64_C2_INV;

    if (!((KEY_WIDTH == 32'd32) || (KEY_WIDTH == 32'd64))) begin : g_bad_width
        $error("murmur_unhasher: KEY_WIDTH must be 32 or 64");
    end

    if ((PROD32_C1 != 32'd1) || (PROD32_C2 != 32'd1) ||
        (PROD64_C1 != 64'd1) || (PROD64_C2 != 64'd1)) begin : g_bad_inverse
        $error("murmur_unhasher: inverse multiplier constant does not invert its partner");
    end

    logic [NUM_STAGES-1:0] valid_s;
    logic [NUM_STAGES-1:0] up_valid_s;
    logic [NUM_STAGES-1:0] down_adv_s;
    logic [KEY_WIDTH-1:0]  stage_d_s [NUM_STAGES];
    logic [KEY_WIDTH-1:0]  stage_q_s [NUM_STAGES];

    assign up_valid_s = {valid_s[NUM_STAGES-2:0], bus.i_valid};

    // Per-stage inverse arithmetic feeding each slot; multiplies wrap at KEY_WIDTH.
    always_comb begin
        stage_d_s[0] = bus.i_data ^ (bus.i_data >> SH_OUTER);
        stage_d_s[1] = stage_q_s[0] * C2_INV_K;
        stage_d_s[2] = stage_q_s[1] ^ (stage_q_s[1] >> SH_MID) ^ ((stage_q_s[1] >> SH_MID2) & MID2_MASK);
        stage_d_s[3] = stage_q_s[2] * C1_INV_K;
        stage_d_s[4] = stage_q_s[3] ^ (stage_q_s[3] >> SH_OUTER);
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // A slot may hand off when the sink is ready or any later slot has a bubble.
        if (k == NUM_STAGES - 1) begin : g_last
            assign down_adv_s[k] = bus.i_ready;
        end else begin : g_mid
            assign down_adv_s[k] = bus.i_ready | ~(&valid_s[NUM_STAGES-1:k+1]);
        end

        murmur_pipe_stage #(
            .KEY_WIDTH (KEY_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid_s[k]),
            .up_data  (stage_d_s[k]),
            .down_adv (down_adv_s[k]),
            .valid    (valid_s[k]),
            .data     (stage_q_s[k])
        );
    end

    assign bus.o_ready = ~valid_s[0] | down_adv_s[0];
    assign bus.o_valid = valid_s[NUM_STAGES-1];
    assign bus.o_data  = stage_q_s[NUM_STAGES-1];
endmodule

// File: doc/murmur_unhasher.md
Name: murmur_unhasher

Overview:
- Inverts the MurMur finalizer (fmix32 / fmix64 variant used by the hashing pipeline). Given a hash value, it recovers the original key.
- The finalizer is bijective when hash width equals key width. This block is the decoder counterpart used for hash-table key reconstruction, debug readback and self-checking round-trip loops.
- Fully pipelined, one result per cycle, valid/ready handshake with per-stage bubble collapse.

Parameters:
- KEY_WIDTH, 32, key/hash width; only 32 and 64 are legal. Any other value is an elaboration error.
- LATENCY, 5, localparam (not overridable); pipeline depth in cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_data  in  KEY_WIDTH  hash value to invert
- i_valid  in  1  i_data valid
- o_ready  out  1  block accepts i_data this cycle
- o_data  out  KEY_WIDTH  recovered key
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data

Behaviour:
- Reset: all stage valid bits, including o_valid, are 0; all data registers and o_data are 0. rst has priority over any handshake in the same cycle. Mid-stream reset discards all in-flight items with no output. o_ready is 1 in the first cycle after reset release.
- Stage functions for KEY_WIDTH=32. Each stage's result is registered.
  - S1: x ^ (x>>16)
  - S2: x * 32'h7ed1b41d (inverse of 32'hc2b2ae35), low 32 bits kept
  - S3: x ^ (x>>13) ^ (x>>26)
  - S4: x * 32'ha5cb9243 (inverse of 32'h85ebca6b), low 32 bits kept
  - S5: x ^ (x>>16)
- Stage functions for KEY_WIDTH=64. Each stage's result is registered.
  - S1, S3, S5: x ^ (x>>33) (self-inverse since 2*33 >= 64)
  - S2: x * 64'h9cb4b2f8129337db (inverse of 64'hc4ceb9fe1a85ec53)
  - S4: x * 64'h4f74430c22a54005 (inverse of 64'hff51afd7ed558ccd)
- Every inverse constant must satisfy C * C_inv ≡ 1 mod 2^KEY_WIDTH. This is enforced by an elaboration-time assertion.
- Multiplies are truncated to KEY_WIDTH bits and never sign-extended.
- Handshake:
  - Input transfer occurs when i_valid && o_ready; output transfer occurs when o_valid && i_ready.
  - Stage k advances when it is empty or stage k+1 advances. The output stage advances when !o_valid || i_ready.
  - o_ready = stage S1 advance condition; it is purely combinational from the stage valids and i_ready, with no dependency on i_valid.
- Latency and throughput:
  - With i_ready held high, an item accepted at cycle t appears with o_valid=1 at cycle t+5.
  - Throughput is 1 item/cycle.
- Backpressure:
  - While i_ready=0 and o_valid=1, o_data and o_valid hold stable.
  - Upstream stages keep filling bubbles until full. Maximum in-flight is 5 items.
  - o_ready drops only when all 5 stages are valid and i_ready=0.
- Simultaneous accept and emit on a full pipe is legal: all stages shift, and no item is lost or duplicated.
- Data registers of invalid stages may update freely. Only the valid bits gate o_valid.
- Ordering is strictly FIFO.

Decomposition:
- Package murmur_pkg holds:
  - Forward constants: MURMUR32_C1/C2, MURMUR64_C1/C2.
  - Inverse constants: MURMUR32_C1_INV/C2_INV, MURMUR64_C1_INV/C2_INV.
  - Shift amounts.
  - Functions fmix_fwd and fmix_inv (width-parameterised), shared with the bench's reference model.
- One sub-module is natural: murmur_pipe_stage (KEY_WIDTH data register plus valid bit, with bubble-collapse advance logic). It is instantiated 5 times; the stage arithmetic stays in the top module.

Test Plan:
- Reset/zero: assert rst for 3 cycles, then feed i_data=0 with i_ready=1 -> o_valid=0 throughout reset; o_data=0 with o_valid=1 exactly 5 cycles after accept.
- Round-trip 32: feed fmix_fwd(k) for k in {1, 0xDEADBEEF, 0xFFFFFFFF, 0x80000000} back-to-back -> outputs equal k in order on 4 consecutive cycles starting at cycle t+5.
- Round-trip 64: KEY_WIDTH=64, feed fmix_fwd(k) for k in {1, 0x0123456789ABCDEF, 2^64-1} -> exact k recovered, latency 5.
- Backpressure: continuous input, i_ready=0 for 8 cycles starting at cycle 7 -> o_ready falls once 5 items are held; o_data stable while stalled; release resumes with no loss or duplication, order preserved.
- Random stress: 10k random keys through fmix_fwd, random i_valid/i_ready at 50% -> scoreboard exact match, in-flight count never exceeds 5.
- Mid-stream reset: 3 items in flight, assert rst 1 cycle -> no stale output after reset; the next accepted item emerges correctly at latency 5.
